// File: rtl/ifu_pkg.sv
// ifu_pkg: shared widths, types and helpers for the prefetching instruction fetch unit
package ifu_pkg;
  localparam int RV_PC_SIZE = 32;
  localparam int RV_IR_SIZE = 32;
  typedef logic [RV_PC_SIZE-1:0] pc_t;
  typedef logic [RV_IR_SIZE-1:0] ir_t;
  typedef struct packed {
    ir_t ir;
    pc_t pc;
  } ifu_ibuf_ent_t;
  function automatic pc_t pc_next(input pc_t pc);
    return pc + RV_PC_SIZE'(4);
  endfunction
endpackage

// File: rtl/ifu_pf_if.sv
// ifu_pf_if: fetch-bus and EXU-side bundles of the IFU
//  ifu_fch_if: req_vld/rdy, req_pc (fetch request); rsp_vld/rdy, rsp_ir (in-order response)
//  ifu_ex_if : req_vld/rdy, req_ir/pc, req_pred_taken/pred_pc (instruction to EXU);
//              rsp_vld/rdy, rsp_taken, rsp_target_pc (branch resolution); fl_req_vld (flush)
//  master = IFU side, slave = memory / EXU side
interface ifu_fch_if;
  import ifu_pkg::*;
  logic req_vld, req_rdy;
  pc_t  req_pc;
  logic rsp_vld, rsp_rdy;
  ir_t  rsp_ir;
  modport master(output req_vld, req_pc, rsp_rdy, input req_rdy, rsp_vld, rsp_ir);
  modport slave(input req_vld, req_pc, rsp_rdy, output req_rdy, rsp_vld, rsp_ir);
endinterface

interface ifu_ex_if;
  import ifu_pkg::*;
  logic req_vld, req_rdy;
  ir_t  req_ir;
  pc_t  req_pc;
  logic req_pred_taken;
  pc_t  req_pred_pc;
  logic rsp_vld, rsp_rdy, rsp_taken;
  pc_t  rsp_target_pc;
  logic fl_req_vld;
  modport master(output req_vld, req_ir, req_pc, req_pred_taken, req_pred_pc, rsp_rdy, fl_req_vld,
                 input req_rdy, rsp_vld, rsp_taken, rsp_target_pc);
  modport slave(input req_vld, req_ir, req_pc, req_pred_taken, req_pred_pc, rsp_rdy, fl_req_vld,
                output req_rdy, rsp_vld, rsp_taken, rsp_target_pc);
endinterface

// File: rtl/ifu_sync_fifo.sv
// ifu_sync_fifo: synchronous FIFO with clear; push/pop allowed together at any occupancy
//  ports: clk, rst_n, push/din, pop/dout (head), clr (empties, wins over push/pop), cnt (occupancy)
module ifu_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  input  logic                       clr,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH+1)-1:0] cnt
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return p == AW'(DEPTH-1) ? '0 : p + 1'b1;
  endfunction
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (clr) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= inc(wp);
      if (pop) rp <= inc(rp);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  assign dout = mem[rp];
endmodule

// File: rtl/ifu_pf.sv
// ifu_pf: prefetching IFU with OST_DEPTH fetches in flight and an IBUF_DEPTH instruction queue
//  ports: clk, rst_n (async, active-low); fch (fetch bus master); ex (EXU request/resolution/flush)
module ifu_pf import ifu_pkg::*; #(
  parameter int  OST_DEPTH  = 2,
  parameter int  IBUF_DEPTH = 4,
  parameter pc_t RESET_PC   = '0
) (
  input logic       clk,
  input logic       rst_n,
  ifu_fch_if.master fch,
  ifu_ex_if.master  ex
);
  localparam int OW = $clog2(OST_DEPTH+1);
  localparam int BW = $clog2(IBUF_DEPTH+1);
  localparam int SW = BW + 1;
  logic          rdy, taken, req_hsk, rsp_hsk, keep, ex_pop;
  logic [OW-1:0] ost_cnt, drop_cnt, pcf_cnt;
  logic [BW-1:0] ibuf_cnt;
  pc_t           pc, pcf_head;
  ifu_ibuf_ent_t ibuf_head;
  // ready flag keeps every output low while reset is asserted
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdy <= 1'b0;
    else rdy <= 1'b1;
  assign taken    = ex.rsp_vld & rdy & ex.rsp_taken;
  assign rsp_hsk  = fch.rsp_vld & rdy;
  // credit: in-flight (stale included) plus buffered never exceeds IBUF_DEPTH
  assign fch.req_vld = rdy & ~taken & (ost_cnt < OW'(OST_DEPTH))
                     & (SW'(ibuf_cnt) + SW'(ost_cnt) < SW'(IBUF_DEPTH));
  assign fch.req_pc  = pc;
  assign fch.rsp_rdy = rdy;
  assign req_hsk = fch.req_vld & fch.req_rdy;
  assign keep    = rsp_hsk & ~taken & (drop_cnt == '0);
  assign ex.req_vld        = (ibuf_cnt != '0) & ~taken;
  assign ex.req_ir         = ibuf_head.ir;
  assign ex.req_pc         = ibuf_head.pc;
  assign ex.req_pred_taken = 1'b0;
  assign ex.req_pred_pc    = '0;
  assign ex.rsp_rdy        = rdy;
  assign ex.fl_req_vld     = taken;
  assign ex_pop = ex.req_vld & ex.req_rdy;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc       <= RESET_PC;
      ost_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      pc       <= taken ? ex.rsp_target_pc : req_hsk ? pc_next(pc) : pc;
      ost_cnt  <= ost_cnt + OW'(req_hsk) - OW'(rsp_hsk);
      // on redirect every request still in flight after this cycle is stale
      drop_cnt <= taken ? ost_cnt - OW'(rsp_hsk) : drop_cnt - OW'(rsp_hsk && drop_cnt != '0);
    end
  ifu_sync_fifo #(.W(RV_PC_SIZE), .DEPTH(OST_DEPTH)) u_pcf (
    .clk(clk), .rst_n(rst_n), .push(req_hsk), .din(pc), .pop(keep), .clr(taken),
    .dout(pcf_head), .cnt(pcf_cnt)
  );
  ifu_sync_fifo #(.W($bits(ifu_ibuf_ent_t)), .DEPTH(IBUF_DEPTH)) u_ibuf (
    .clk(clk), .rst_n(rst_n), .push(keep), .din({fch.rsp_ir, pcf_head}), .pop(ex_pop),
    .clr(taken), .dout(ibuf_head), .cnt(ibuf_cnt)
  );
  // a kept response always has its PC waiting in the PC FIFO
  assert property (@(posedge clk) disable iff (!rst_n) !(keep && pcf_cnt == '0));
endmodule
